chipbus_arb: RTL

- Sequences and shares the buffered chip bus (chip-select, buffered rd/wr strobes, buffered data, 10-bit address) between two requesters.
- Requester Z: the ZX-bus front end. It issues single-cycle start pulses and has strict priority.
- Requester I: an internal master, e.g. a W5300 interrupt/status poller. It uses a level req/ack handshake.
- The block produces fixed-width, registered strobes with a recovery gap, so that W5300 and SL811 timing is met for both requesters.

---
 rtl/chipbus_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/chipbus_arb.sv
// Two-requester sequencer for the buffered W5300/SL811 chip bus.
// Z (pulse, priority, one pending slot) and I (req/ack) share fixed-width strobes.
module chipbus_arb #(
    parameter int STRB_LEN = 5,
    parameter int RECOV    = 2,
    parameter int AW       = 10
) (
    input  logic          fclk,
    input  logic          rst,
    input  logic          z_rd_req,
    input  logic          z_wr_req,
    input  logic          z_sel,
    input  logic [AW-1:0] z_addr,
    input  logic [7:0]    z_wdata,
    output logic [7:0]    z_rdata,
    output logic          z_done,
    output logic          z_err,
    input  logic          i_req,
    input  logic          i_we,
    input  logic          i_sel,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    i_rdata,
    output logic          i_ack,
    output logic          w5300_cs_n,
    output logic          sl811_cs_n,
    output logic          brd_n,
    output logic          bwr_n,
    output logic [AW-1:0] b_addr,
    output logic [7:0]    b_dout,
    output logic          b_doe,
    input  logic [7:0]    b_din,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, STRB, REC} state_t;

    state_t state, state_nx;
    logic [2:0] cnt;

    logic          slot_full, slot_we, slot_sel;
    logic [AW-1:0] slot_addr;
    logic [7:0]    slot_wdata;

    logic owner_z, cur_we;
    logic grant_z, grant_i, fin;
    logic g_we, g_sel;
    logic [AW-1:0] g_addr;
    logic [7:0]    g_wdata;

    logic z_one, z_both, last;

    assign z_one  = z_rd_req ^ z_wr_req;
    assign z_both = z_rd_req & z_wr_req;
    assign last   = (cnt == 3'd1);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nx = state;
        grant_z  = 1'b0;
        grant_i  = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                if (slot_full || z_one) begin
                    grant_z  = 1'b1;
                    state_nx = STRB;
                end else if (i_req) begin
                    grant_i  = 1'b1;
                    state_nx = STRB;
                end
            end
            STRB: begin
                if (last) begin
                    fin      = 1'b1;
                    state_nx = (RECOV == 0) ? IDLE : REC;
                end
            end
            REC: begin
                if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A full slot is always older than a same-cycle pulse, so it goes first.
    always_comb begin
        g_we    = i_we;
        g_sel   = i_sel;
        g_addr  = i_addr;
        g_wdata = i_wdata;
        if (slot_full) begin
            g_we    = slot_we;
            g_sel   = slot_sel;
            g_addr  = slot_addr;
            g_wdata = slot_wdata;
        end else if (z_one) begin
            g_we    = z_wr_req;
            g_sel   = z_sel;
            g_addr  = z_addr;
            g_wdata = z_wdata;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            slot_full  <= 1'b0;
            slot_we    <= 1'b0;
            slot_sel   <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            owner_z    <= 1'b0;
            cur_we     <= 1'b0;
            w5300_cs_n <= 1'b1;
            sl811_cs_n <= 1'b1;
            brd_n      <= 1'b1;
            bwr_n      <= 1'b1;
            b_doe      <= 1'b0;
            b_addr     <= '0;
            b_dout     <= '0;
            z_rdata    <= '0;
            i_rdata    <= '0;
            z_done     <= 1'b0;
            i_ack      <= 1'b0;
            z_err      <= 1'b0;
        end else begin
            state  <= state_nx;
            z_done <= 1'b0;
            i_ack  <= 1'b0;

            if (grant_z || grant_i) cnt <= 3'(STRB_LEN);
            else if (fin)           cnt <= 3'(RECOV);
            else if (cnt != 3'd0)   cnt <= cnt - 3'd1;

            if (z_both || (z_one && slot_full)) z_err <= 1'b1;
            if (grant_z && slot_full) slot_full <= 1'b0;
            // In IDLE an empty slot means the pulse is granted directly.
            if (z_one && !slot_full && state != IDLE) begin
                slot_full  <= 1'b1;
                slot_we    <= z_wr_req;
                slot_sel   <= z_sel;
                slot_addr  <= z_addr;
                slot_wdata <= z_wdata;
            end

            if (grant_z || grant_i) begin
                owner_z    <= grant_z;
                cur_we     <= g_we;
                w5300_cs_n <= g_sel;
                sl811_cs_n <= !g_sel;
                brd_n      <= g_we;
                bwr_n      <= !g_we;
                b_doe      <= g_we;
                b_addr     <= g_addr;
                b_dout     <= g_wdata;
            end

            if (fin) begin
                w5300_cs_n <= 1'b1;
                sl811_cs_n <= 1'b1;
                brd_n      <= 1'b1;
                bwr_n      <= 1'b1;
                b_doe      <= 1'b0;
                if (owner_z) begin
                    z_done <= 1'b1;
                    if (!cur_we) z_rdata <= b_din;
                end else begin
                    i_ack <= 1'b1;
                    if (!cur_we) i_rdata <= b_din;
                end
            end
        end
    end

endmodule
